// File: rtl/csr_access_ctrl_pkg.sv
// Shared definitions for the CSR access controller: opcode, funct3 encodings,
// legal CSR numbers and FSM state encoding.
package csr_access_ctrl_pkg;

   localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0]  F3_PRIV   = 3'b000;
   localparam logic [2:0]  F3_CSRRW  = 3'b001;
   localparam logic [2:0]  F3_CSRRS  = 3'b010;
   localparam logic [2:0]  F3_CSRRC  = 3'b011;
   localparam logic [2:0]  F3_RSVD   = 3'b100;
   localparam logic [2:0]  F3_CSRRWI = 3'b101;
   localparam logic [2:0]  F3_CSRRSI = 3'b110;
   localparam logic [2:0]  F3_CSRRCI = 3'b111;

   localparam logic [11:0] CSR_CYCLEL = 12'hC00;
   localparam logic [11:0] CSR_TIMEL  = 12'hC01;
   localparam logic [11:0] CSR_INSL   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH = 12'hC80;
   localparam logic [11:0] CSR_TIMEH  = 12'hC81;
   localparam logic [11:0] CSR_INSH   = 12'hC82;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_WB      = 2'd3
   } state_e;

   function automatic logic csr_addr_legal(input logic [11:0] addr);
      return (addr == CSR_CYCLEL) || (addr == CSR_TIMEL) || (addr == CSR_INSL) ||
             (addr == CSR_CYCLEH) || (addr == CSR_TIMEH) || (addr == CSR_INSH);
   endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// Core/CSR-unit/register-file signal bundle of the CSR access controller.
// master = controller side, slave = environment side.
interface csr_access_ctrl_if #(parameter int XLEN = 32);
   logic            ins_valid;
   logic            ins_ready;
   logic [31:0]     ins;
   logic [XLEN-1:0] rs1_data;
   logic            csr_read;
   logic [11:0]     csr_addr;
   logic            csr_write;
   logic            csr_set;
   logic            csr_clr;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] csr_rdata;
   logic            wb_valid;
   logic            wb_ready;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ins_ret;
   logic            illegal;

   modport master (
      input  ins_valid, ins, rs1_data, csr_rdata, wb_ready,
      output ins_ready, csr_read, csr_addr, csr_write, csr_set, csr_clr, csr_wdata,
             wb_valid, wb_rd, wb_data, ins_ret, illegal
   );

   modport slave (
      output ins_valid, ins, rs1_data, csr_rdata, wb_ready,
      input  ins_ready, csr_read, csr_addr, csr_write, csr_set, csr_clr, csr_wdata,
             wb_valid, wb_rd, wb_data, ins_ret, illegal
   );
endinterface

// File: rtl/csr_access_ctrl_decode.sv
// Combinational decoder of a SYSTEM/CSR instruction word.
// Immediate forms (funct3 1x1/11x) are legal only when CSR_IMM_EN is defined.
module csr_access_ctrl_decode
   import csr_access_ctrl_pkg::*;
#(
   parameter bit CHECK_ADDR = 1'b1
) (
   input  logic [31:0] ins_i,
   output logic        legal_o,
   output logic        op_write_o,
   output logic        op_set_o,
   output logic        op_clr_o,
   output logic        use_imm_o,
   output logic [4:0]  rd_o,
   output logic [4:0]  rs1_o,
   output logic [11:0] addr_o
);
   logic [2:0] funct3_s;
   logic       f3_ok_s;

   assign funct3_s = ins_i[14:12];
   assign rd_o     = ins_i[11:7];
   assign rs1_o    = ins_i[19:15];
   assign addr_o   = ins_i[31:20];

   // funct3 -> operation class
   always_comb begin
      f3_ok_s    = 1'b0;
      op_write_o = 1'b0;
      op_set_o   = 1'b0;
      op_clr_o   = 1'b0;
      use_imm_o  = 1'b0;
      case (funct3_s)
         F3_CSRRW:  begin f3_ok_s = 1'b1; op_write_o = 1'b1; end
         F3_CSRRS:  begin f3_ok_s = 1'b1; op_set_o   = 1'b1; end
         F3_CSRRC:  begin f3_ok_s = 1'b1; op_clr_o   = 1'b1; end
`ifdef CSR_IMM_EN
         F3_CSRRWI: begin f3_ok_s = 1'b1; op_write_o = 1'b1; use_imm_o = 1'b1; end
         F3_CSRRSI: begin f3_ok_s = 1'b1; op_set_o   = 1'b1; use_imm_o = 1'b1; end
         F3_CSRRCI: begin f3_ok_s = 1'b1; op_clr_o   = 1'b1; use_imm_o = 1'b1; end
`else
         F3_CSRRWI, F3_CSRRSI, F3_CSRRCI: f3_ok_s = 1'b0;
`endif
         F3_PRIV, F3_RSVD: f3_ok_s = 1'b0;
         default:          f3_ok_s = 1'b0;
      endcase
   end

   assign legal_o = (ins_i[6:0] == OPC_SYSTEM) && f3_ok_s &&
                    (!CHECK_ADDR || csr_addr_legal(addr_o));

endmodule

// File: rtl/csr_access_ctrl.sv
// CSR bus initiator: one SYSTEM instruction at a time -> single-cycle CSR strobe,
// read-data capture and register-file writeback. Optional macro: CSR_IMM_EN.
module csr_access_ctrl
   import csr_access_ctrl_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter bit CHECK_ADDR = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   csr_access_ctrl_if.master  bus
);
   state_e          state_q, state_d;
   logic            read_q, read_d, write_q, write_d, set_q, set_d, clr_q, clr_d;
   logic [11:0]     addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d, wb_data_q, wb_data_d;
   logic [4:0]      rd_q, rd_d;
   logic            wb_valid_q, wb_valid_d, ret_q, ret_d, illegal_q, illegal_d;

   logic            dec_legal_s, dec_write_s, dec_set_s, dec_clr_s, dec_imm_s;
   logic [4:0]      dec_rd_s, dec_rs1_s;
   logic [11:0]     dec_addr_s;
   logic [XLEN-1:0] operand_s;

   csr_access_ctrl_decode #(.CHECK_ADDR(CHECK_ADDR)) u_decode (
      .ins_i      (bus.ins),
      .legal_o    (dec_legal_s),
      .op_write_o (dec_write_s),
      .op_set_o   (dec_set_s),
      .op_clr_o   (dec_clr_s),
      .use_imm_o  (dec_imm_s),
      .rd_o       (dec_rd_s),
      .rs1_o      (dec_rs1_s),
      .addr_o     (dec_addr_s)
   );

   assign operand_s = dec_imm_s ? {{(XLEN-5){1'b0}}, dec_rs1_s} : bus.rs1_data;

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      read_d     = 1'b0;
      write_d    = 1'b0;
      set_d      = 1'b0;
      clr_d      = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      wb_data_d  = wb_data_q;
      wb_valid_d = wb_valid_q;
      ret_d      = 1'b0;
      illegal_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.ins_valid) begin
               if (dec_legal_s) begin
                  // set/clr with a zero source never modify the CSR
                  state_d = ST_ACCESS;
                  addr_d  = dec_addr_s;
                  wdata_d = operand_s;
                  rd_d    = dec_rd_s;
                  read_d  = (dec_rd_s != 5'd0);
                  write_d = dec_write_s;
                  set_d   = dec_set_s && (dec_rs1_s != 5'd0);
                  clr_d   = dec_clr_s && (dec_rs1_s != 5'd0);
               end else begin
                  illegal_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            wb_data_d = bus.csr_rdata;
            if (rd_q != 5'd0) begin
               state_d    = ST_WB;
               wb_valid_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
               ret_d   = 1'b1;
            end
         end
         ST_WB: begin
            if (bus.wb_ready) begin
               state_d    = ST_IDLE;
               wb_valid_d = 1'b0;
            end else begin
               wb_valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         read_q     <= 1'b0;
         write_q    <= 1'b0;
         set_q      <= 1'b0;
         clr_q      <= 1'b0;
         addr_q     <= 12'h000;
         wdata_q    <= '0;
         rd_q       <= 5'd0;
         wb_data_q  <= '0;
         wb_valid_q <= 1'b0;
         ret_q      <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         read_q     <= read_d;
         write_q    <= write_d;
         set_q      <= set_d;
         clr_q      <= clr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         wb_data_q  <= wb_data_d;
         wb_valid_q <= wb_valid_d;
         ret_q      <= ret_d;
         illegal_q  <= illegal_d;
      end
   end

   assign bus.ins_ready = (state_q == ST_IDLE);
   assign bus.csr_read  = read_q;
   assign bus.csr_write = write_q;
   assign bus.csr_set   = set_q;
   assign bus.csr_clr   = clr_q;
   assign bus.csr_addr  = addr_q;
   assign bus.csr_wdata = wdata_q;
   assign bus.wb_valid  = wb_valid_q;
   assign bus.wb_rd     = rd_q;
   assign bus.wb_data   = wb_data_q;
   // writeback retirement is reported in the handshake cycle itself
   assign bus.ins_ret   = ret_q | (wb_valid_q & bus.wb_ready);
   assign bus.illegal   = illegal_q;

endmodule
